// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares the multi-cycle instruction ROM between instruction fetch (port 0) and debug (port 1)
module inst_rom_arbiter #(
   parameter int AW        = 10,
   parameter int DW        = 32,
   parameter int ROM_DELAY = 3,
   parameter int TIMEOUT   = 15,
   parameter int STARVE    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_data,
   output logic          if_ack,
   input  logic          dbg_req,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data,
   output logic          dbg_ack,
   output logic          rom_cs,
   output logic [AW-1:0] rom_a,
   input  logic [DW-1:0] rom_spo,
   input  logic          rom_ack,
   output logic          timeout_err
);
   typedef enum logic [1:0] {DRAIN, IDLE, ACCESS, RELEASE} state_t;
   localparam int DCW = $clog2(ROM_DELAY + 2);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam int SCW = $clog2(STARVE + 2);
   state_t         state;
   logic           gnt;
   logic [DCW-1:0] drain_cnt;
   logic [TCW-1:0] tmo_cnt;
   logic [SCW-1:0] starve_cnt;
   logic [AW-1:0]  prev_a;
   logic           pick_dbg;
   logic           gnt_req;
   assign rom_a    = gnt ? dbg_addr : if_addr;
   assign gnt_req  = gnt ? dbg_req : if_req;
   assign pick_dbg = dbg_req && (!if_req || starve_cnt == SCW'(STARVE));
   // Arbitration FSM: drain after reset, grant, run the cs/ack handshake, release for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= DRAIN;
         gnt         <= 1'b0;
         drain_cnt   <= '0;
         tmo_cnt     <= '0;
         starve_cnt  <= '0;
         prev_a      <= '0;
         rom_cs      <= 1'b0;
         if_ack      <= 1'b0;
         dbg_ack     <= 1'b0;
         if_data     <= '0;
         dbg_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if_ack  <= 1'b0;
         dbg_ack <= 1'b0;
         if (!dbg_req) starve_cnt <= '0;
         case (state)
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == DCW'(ROM_DELAY)) state <= IDLE;
            end
            IDLE, RELEASE: begin
               state <= IDLE;
               if (if_req || dbg_req) begin
                  state   <= ACCESS;
                  rom_cs  <= 1'b1;
                  gnt     <= pick_dbg;
                  tmo_cnt <= '0;
                  prev_a  <= pick_dbg ? dbg_addr : if_addr;
                  if (pick_dbg) starve_cnt <= '0;
                  else if (dbg_req && starve_cnt != SCW'(STARVE)) starve_cnt <= starve_cnt + 1'b1;
               end
            end
            ACCESS: begin
               prev_a <= rom_a;
               if (!gnt_req) begin
                  state  <= RELEASE;
                  rom_cs <= 1'b0;
               end else if (rom_ack) begin
                  state  <= RELEASE;
                  rom_cs <= 1'b0;
                  if (gnt) begin
                     dbg_data <= rom_spo;
                     dbg_ack  <= 1'b1;
                  end else begin
                     if_data <= rom_spo;
                     if_ack  <= 1'b1;
                  end
               end else if (rom_a != prev_a) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TCW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= RELEASE;
                  rom_cs      <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= DRAIN;
         endcase
      end
   end
endmodule
